// File: rtl/his_builder_fsm.sv
// Per-pixel coarse ToF histogram builder: bins time stamps over one acquisition and publishes the peak bin centre per pixel.
// Optional HIS_NOPHOTON_FILTER_EN: the all-ones time stamp uses up its sample slot but is not binned.
module his_builder_fsm #(
  parameter int NP                = 10,
  parameter int PIXEL_NUM_PER_RAM = 3,
  parameter int SAMPLES_PER_PIXEL = 2,
  parameter int SHOTS_PER_ACQ     = 2,
  parameter int BIN_BITS          = 4,
  parameter int CNT_W             = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          wrEn,
  input  logic [NP-1:0] data,
  output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM]
);

  localparam int PIX   = PIXEL_NUM_PER_RAM;
  localparam int NBINS = 1 << BIN_BITS;
  localparam int PW    = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int SW    = (SAMPLES_PER_PIXEL > 1) ? $clog2(SAMPLES_PER_PIXEL) : 1;
  localparam int HW    = (SHOTS_PER_ACQ > 1) ? $clog2(SHOTS_PER_ACQ) : 1;

  typedef enum logic [1:0] {ACCUM, LATCH, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       pix_q;
  logic [SW-1:0]       samp_q;
  logic [HW-1:0]       shot_q;
  logic [CNT_W-1:0]    cnt_q  [PIX][NBINS];
  logic [CNT_W-1:0]    max_q  [PIX];
  logic [BIN_BITS-1:0] peak_q [PIX];
  logic [NP-1:0]       result_q [PIX];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [NP-1:0] bin_centre(input logic [BIN_BITS-1:0] b);
    logic [NP-1:0] v;
    v = '0;
    v[NP-1 -: BIN_BITS] = b;
    v[NP-BIN_BITS-1]    = 1'b1;
    return v;
  endfunction

  logic [BIN_BITS-1:0] bin;
  logic                nophoton;
  logic                binnable;
  logic                take;
  logic                last;
  logic [CNT_W-1:0]    new_cnt;

  assign bin      = data[NP-1 -: BIN_BITS];
  assign nophoton = &data;
`ifdef HIS_NOPHOTON_FILTER_EN
  assign binnable = ~nophoton;
`else
  assign binnable = 1'b1 | nophoton;
`endif
  assign take     = (state_q == ACCUM) && wrEn;
  assign last     = (samp_q == SW'(SAMPLES_PER_PIXEL - 1)) &&
                    (pix_q  == PW'(PIX - 1)) &&
                    (shot_q == HW'(SHOTS_PER_ACQ - 1));
  assign new_cnt  = sat_inc(cnt_q[pix_q][bin]);

  assign peakResult = result_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state_q <= ACCUM;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (take && last) state_d = LATCH;
      LATCH:   state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pix_q  <= '0;
      samp_q <= '0;
      shot_q <= '0;
      for (int p = 0; p < PIX; p++) begin
        max_q[p]    <= '0;
        peak_q[p]   <= '0;
        result_q[p] <= '0;
        for (int b = 0; b < NBINS; b++) cnt_q[p][b] <= '0;
      end
    end else begin
      case (state_q)
        ACCUM: if (take) begin
          // Order within an acquisition: sample fastest, then pixel, then shot.
          if (samp_q == SW'(SAMPLES_PER_PIXEL - 1)) begin
            samp_q <= '0;
            if (pix_q == PW'(PIX - 1)) begin
              pix_q  <= '0;
              shot_q <= (shot_q == HW'(SHOTS_PER_ACQ - 1)) ? '0 : shot_q + 1'b1;
            end else begin
              pix_q <= pix_q + 1'b1;
            end
          end else begin
            samp_q <= samp_q + 1'b1;
          end
          if (binnable) begin
            cnt_q[pix_q][bin] <= new_cnt;
            // Strict compare: on a tie the bin that reached the count first keeps the peak.
            if (new_cnt > max_q[pix_q]) begin
              max_q[pix_q]  <= new_cnt;
              peak_q[pix_q] <= bin;
            end
          end
        end
        LATCH: begin
          for (int p = 0; p < PIX; p++)
            result_q[p] <= (max_q[p] == '0) ? '1 : bin_centre(peak_q[p]);
        end
        CLEAR: begin
          pix_q  <= '0;
          samp_q <= '0;
          shot_q <= '0;
          for (int p = 0; p < PIX; p++) begin
            max_q[p]  <= '0;
            peak_q[p] <= '0;
            for (int b = 0; b < NBINS; b++) cnt_q[p][b] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Directed bench for his_builder_fsm with default parameters; expectations follow the build's filter macro.
module tb_his_builder_fsm;
  localparam int NP  = 10;
  localparam int PIX = 3;
`ifdef HIS_NOPHOTON_FILTER_EN
  localparam int NOPH_EXP = 1023;
`else
  localparam int NOPH_EXP = 992;
`endif

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          wrEn = 1'b0;
  logic [NP-1:0] data = '0;
  logic [NP-1:0] peakResult [PIX];

  int errors = 0;
  int checks = 0;

  int s1 [12] = '{108, 511, 1022, 1022, 200, 90, 511, 1023, 90, 90, 90, 90};
  int s2 [12] = '{300, 500, 50, 1000, 48, 90, 600, 500, 1000, 1023, 120, 90};
  int s3 [12] = '{100, 100, 1023, 1023, 700, 700, 100, 100, 1023, 1023, 700, 700};

  always #5 clk = ~clk;

  his_builder_fsm dut (
    .clk        (clk),
    .res        (res),
    .wrEn       (wrEn),
    .data       (data),
    .peakResult (peakResult)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int e0, input int e1, input int e2);
    check({tag, "_p0"}, 32'(peakResult[0]), e0);
    check({tag, "_p1"}, 32'(peakResult[1]), e1);
    check({tag, "_p2"}, 32'(peakResult[2]), e2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int v);
    data = v[NP-1:0];
    wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic run_acq(input int v [12], input int gap);
    for (int i = 0; i < 12; i++) begin
      push(v[i]);
      if (gap > 0 && i < 11) idle(gap);
    end
  endtask

  initial begin
    idle(2);
    check_res("reset", 0, 0, 0);
    res = 1'b1;
    idle(1);

    // Acquisition 1, then wrEn held high through LATCH/CLEAR: those samples must be dropped.
    run_acq(s1, 0);
    check("latency_hold", 32'(peakResult[0]), 0);
    data = 10'd1022;
    wrEn = 1'b1;
    idle(2);
    wrEn = 1'b0;
    check_res("acq1", 480, 992, 96);
    idle(2);

    run_acq(s2, 0);
    idle(2);
    check_res("acq2", 480, 992, 96);

    // Partial acquisition interrupted by reset.
    for (int i = 0; i < 5; i++) push(s3[i]);
    #2 res = 1'b0;
    #1 check_res("reset_mid", 0, 0, 0);
    @(negedge clk);
    res = 1'b1;
    idle(1);

    run_acq(s3, 0);
    idle(2);
    check_res("nophoton", 96, NOPH_EXP, 672);

    run_acq(s1, 1);
    idle(2);
    check_res("gapped", 480, 992, 96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
